// File: rtl/mult_responder.sv
// -----------------------------------------------------------------------------
// mult_responder
//
// Responder end of the multiplier request/ack protocol. It accepts a signed
// 16x16 operand pair with one parity bit per operand and checks both parities.
// It then computes the signed 32-bit product with one shift-add step per cycle
// and returns the result, its parity and a one-cycle ready strobe.
//
// Handshake: in IDLE, a rising edge that samples req=1 captures the operands.
// ack is high for exactly the following cycle. req is ignored outside IDLE.
// The initiator drops req in the cycle it sees ack. If req is still high when
// the FSM returns to IDLE, that is treated as a new request. result_rdy is a
// one-cycle strobe that qualifies result / result_parity / arg_parity_error.
// Those three outputs then hold their values until the next accepted request
// clears them.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               request from the initiator
//   arg_a, arg_b      two's-complement operands (16 bit)
//   arg_a_parity      must equal ^arg_a
//   arg_b_parity      must equal ^arg_b
//   ack               one-cycle accept pulse
//   result            signed product (32 bit), 0 on parity error
//   result_parity     ^result, 0 on parity error
//   result_rdy        one-cycle result-valid pulse
//   arg_parity_error  1 if either operand parity mismatched
//   dbg_state         current FSM state (IDLE=0, CALC=1, DONE=2, ERR=3)
// -----------------------------------------------------------------------------
module mult_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] arg_a,
    input  logic        arg_a_parity,
    input  logic [15:0] arg_b,
    input  logic        arg_b_parity,
    output logic        ack,
    output logic [31:0] result,
    output logic        result_parity,
    output logic        result_rdy,
    output logic        arg_parity_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_mag_a;
    logic [15:0] r_mag_b;
    logic        r_neg;
    logic [3:0]  r_cnt;
    logic [31:0] r_acc;
    logic        r_ack;
    logic [31:0] r_result;
    logic        r_result_parity;
    logic        r_rdy;
    logic        r_perr;

    logic        w_par_ok;
    logic [15:0] w_mag_a;
    logic [15:0] w_mag_b;
    logic [31:0] w_final;

    // Checking the live inputs on the accepting edge gives the same answer as
    // checking the captured copy, and lets the FSM branch straight to CALC/ERR.
    assign w_par_ok = ((^arg_a) == arg_a_parity) && ((^arg_b) == arg_b_parity);

    // Magnitudes as unsigned 16-bit values. -32768 maps to 0x8000, which is
    // still its correct unsigned magnitude, so no extra bit is needed.
    assign w_mag_a = arg_a[15] ? (~arg_a + 16'd1) : arg_a;
    assign w_mag_b = arg_b[15] ? (~arg_b + 16'd1) : arg_b;

    // The largest magnitude product is 2^30, so the 32-bit negation cannot
    // overflow.
    assign w_final = r_neg ? (~r_acc + 32'd1) : r_acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = w_par_ok ? S_CALC : S_ERR;
                end
            end
            S_CALC: begin
                if (r_cnt == 4'd15) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a         <= 16'd0;
            r_mag_b         <= 16'd0;
            r_neg           <= 1'b0;
            r_cnt           <= 4'd0;
            r_acc           <= 32'd0;
            r_ack           <= 1'b0;
            r_result        <= 32'd0;
            r_result_parity <= 1'b0;
            r_rdy           <= 1'b0;
            r_perr          <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_ack           <= 1'b1;
                        r_mag_a         <= w_mag_a;
                        r_mag_b         <= w_mag_b;
                        r_neg           <= arg_a[15] ^ arg_b[15];
                        r_cnt           <= 4'd0;
                        r_acc           <= 32'd0;
                        r_result        <= 32'd0;
                        r_result_parity <= 1'b0;
                        r_perr          <= 1'b0;
                    end
                end
                S_CALC: begin
                    // Step i adds mag_a shifted by i when bit i of mag_b is set.
                    if (r_mag_b[r_cnt]) begin
                        r_acc <= r_acc + ({16'd0, r_mag_a} << r_cnt);
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                S_DONE: begin
                    r_result        <= w_final;
                    r_result_parity <= ^w_final;
                    r_rdy           <= 1'b1;
                end
                S_ERR: begin
                    r_result        <= 32'd0;
                    r_result_parity <= 1'b0;
                    r_perr          <= 1'b1;
                    r_rdy           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ack              = r_ack;
    assign result           = r_result;
    assign result_parity    = r_result_parity;
    assign result_rdy       = r_rdy;
    assign arg_parity_error = r_perr;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_mult_responder.sv
module tb_mult_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [15:0] arg_a;
  logic        arg_a_parity;
  logic [15:0] arg_b;
  logic        arg_b_parity;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mult_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one request. Inputs change on the falling edge; outputs are sampled
  // on the falling edge. lat = k means result_rdy was seen in the cycle after
  // E_k, where E0 is the accepting edge. lat = -1 means it was never seen.
  task automatic do_req(input logic [15:0] a, input logic ap,
                        input logic [15:0] b, input logic bp,
                        output logic ack_ok, output logic err_at_ack,
                        output logic [31:0] res_at_ack, output int lat,
                        output logic [31:0] res, output logic rp,
                        output logic perr, output logic rdy_after,
                        output logic [31:0] held_res, output int extra_acks);
    @(negedge clk);
    arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1'b1;
    @(negedge clk);
    ack_ok = ack; err_at_ack = arg_parity_error; res_at_ack = result;
    req = 1'b0;
    arg_a = 16'($urandom); arg_b = 16'($urandom);
    arg_a_parity = 1'($urandom); arg_b_parity = 1'($urandom);
    lat = -1; extra_acks = 0;
    res = 32'hDEAD_BEEF; rp = 1'bx; perr = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack) extra_acks++;
      if (result_rdy) begin
        lat = k; res = result; rp = result_parity; perr = arg_parity_error;
        break;
      end
    end
    @(negedge clk);
    rdy_after = result_rdy;
    held_res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0;
    arg_a = 16'd0; arg_b = 16'd0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    if ({ack, result, result_parity, result_rdy, arg_parity_error} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b res=%h rp=%b rdy=%b perr=%b, want all 0",
               ack, result, result_parity, result_rdy, arg_parity_error);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    checks++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Directed vectors: {a, b, expected result, expected result parity}.
  task automatic test_products();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] vr [4];
    logic        vp [4];
    logic ak, ea, rp, pe, ra; logic [31:0] rak, res, hr; int lat, xa;
    va[0] = 16'd3;     vb[0] = 16'd4;     vr[0] = 32'h0000_000C; vp[0] = 1'b0;
    va[1] = 16'h8000;  vb[1] = 16'h8000;  vr[1] = 32'h4000_0000; vp[1] = 1'b1;
    va[2] = 16'h7FFF;  vb[2] = 16'h8000;  vr[2] = 32'hC000_8000; vp[2] = 1'b1;
    va[3] = 16'h0000;  vb[3] = 16'h7FFF;  vr[3] = 32'h0000_0000; vp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(va[i], ^va[i], vb[i], ^vb[i], ak, ea, rak, lat, res, rp, pe, ra, hr, xa);
      if (ak !== 1'b1) begin errors++; $display("FAIL prod%0d_ack: got %b want 1", i, ak); end
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL prod%0d_latency: got %0d want 17", i, lat); end
      checks++;
      if (res !== vr[i]) begin errors++; $display("FAIL prod%0d_result: got %h want %h", i, res, vr[i]); end
      checks++;
      if (rp !== vp[i]) begin errors++; $display("FAIL prod%0d_parity: got %b want %b", i, rp, vp[i]); end
      checks++;
      if (pe !== 1'b0) begin errors++; $display("FAIL prod%0d_perr: got %b want 0", i, pe); end
      checks++;
      if (ra !== 1'b0) begin errors++; $display("FAIL prod%0d_rdy_width: got %b want 0", i, ra); end
      checks++;
      if (hr !== vr[i]) begin errors++; $display("FAIL prod%0d_hold: got %h want %h", i, hr, vr[i]); end
      checks++;
      if (xa !== 0) begin errors++; $display("FAIL prod%0d_extra_ack: got %0d want 0", i, xa); end
      checks++;
    end
  endtask

  task automatic test_parity_error();
    logic ak, ea, rp, pe, ra; logic [31:0] rak, res, hr; int lat, xa;
    // 0x0001 has parity 1; it is sent with parity 0.
    do_req(16'h0001, 1'b0, 16'd5, 1'b0, ak, ea, rak, lat, res, rp, pe, ra, hr, xa);
    if (lat !== 1) begin errors++; $display("FAIL perr_latency: got %0d want 1", lat); end
    checks++;
    if (pe !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b want 1", pe); end
    checks++;
    if (res !== 32'd0 || rp !== 1'b0) begin
      errors++; $display("FAIL perr_result: got %h/%b want 0/0", res, rp);
    end
    checks++;
    if (arg_parity_error !== 1'b1) begin
      errors++; $display("FAIL perr_hold: got %b want 1", arg_parity_error);
    end
    checks++;
    // The next good request clears the flag when it is accepted.
    do_req(16'd7, 1'b1, 16'd6, 1'b0, ak, ea, rak, lat, res, rp, pe, ra, hr, xa);
    if (ea !== 1'b0) begin errors++; $display("FAIL perr_clear_at_ack: got %b want 0", ea); end
    checks++;
    if (res !== 32'd42 || pe !== 1'b0 || rp !== 1'b1) begin
      errors++; $display("FAIL perr_next_good: got %h/%b/%b want 0000002a/0/1", res, pe, rp);
    end
    checks++;
    // Result from the previous transaction (42) is cleared when the next one is accepted.
    do_req(16'd1, 1'b1, 16'd1, 1'b1, ak, ea, rak, lat, res, rp, pe, ra, hr, xa);
    if (rak !== 32'd0) begin errors++; $display("FAIL result_clear_at_ack: got %h want 0", rak); end
    checks++;
  endtask

  task automatic test_held_req();
    int ack_c[$];
    int rdy_c[$];
    logic [31:0] first_res;
    first_res = 32'd0;
    @(negedge clk);
    arg_a = 16'd2; arg_a_parity = 1'b1; arg_b = 16'hFFFD; arg_b_parity = 1'b1; req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack) ack_c.push_back(c);
      if (result_rdy) begin
        rdy_c.push_back(c);
        if (rdy_c.size() == 1) first_res = result;
      end
      if (c == 20) req = 1'b0;
    end
    if (ack_c.size() !== 2) begin errors++; $display("FAIL held_ack_count: got %0d want 2", ack_c.size()); end
    else begin
      if (ack_c[0] !== 1 || ack_c[1] !== 19) begin
        errors++; $display("FAIL held_ack_cycles: got %0d,%0d want 1,19", ack_c[0], ack_c[1]);
      end
      checks++;
    end
    checks++;
    if (rdy_c.size() !== 2) begin errors++; $display("FAIL held_rdy_count: got %0d want 2", rdy_c.size()); end
    else begin
      if (rdy_c[0] !== 18 || rdy_c[1] !== 36) begin
        errors++; $display("FAIL held_rdy_cycles: got %0d,%0d want 18,36", rdy_c[0], rdy_c[1]);
      end
      checks++;
    end
    checks++;
    if (first_res !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL held_result: got %h want fffffffa", first_res);
    end
    checks++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    int rdy_n;
    logic ak, ea, rp, pe, ra; logic [31:0] rak, res, hr; int lat, xa;
    @(negedge clk);
    arg_a = 16'd100; arg_a_parity = 1'b1; arg_b = 16'd9; arg_b_parity = 1'b0; req = 1'b1;
    @(posedge clk);              // E0
    @(negedge clk); req = 1'b0;
    repeat (8) @(posedge clk);   // E8
    #2 rst_n = 1'b0;
    #1;
    if ({ack, result, result_parity, result_rdy, arg_parity_error} !== 36'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got ack=%b res=%h rp=%b rdy=%b perr=%b st=%0d, want all 0",
               ack, result, result_parity, result_rdy, arg_parity_error, dbg_state);
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    rdy_n = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (result_rdy) rdy_n++;
    end
    if (rdy_n !== 0) begin errors++; $display("FAIL midreset_no_rdy: got %0d want 0", rdy_n); end
    checks++;
    do_req(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, ak, ea, rak, lat, res, rp, pe, ra, hr, xa);
    if (lat !== 17 || res !== 32'd1 || rp !== 1'b1 || pe !== 1'b0) begin
      errors++; $display("FAIL midreset_next: got lat=%0d res=%h rp=%b perr=%b want 17/00000001/1/0",
                         lat, res, rp, pe);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [15:0] a, b; logic ap, bp, bad;
    logic [31:0] exp_q[$];
    logic [31:0] exp_r;
    logic ak, ea, rp, pe, ra; logic [31:0] rak, res, hr; int lat, xa, sel;
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : (sel == 2) ? 16'h0000 : 16'($urandom);
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : (sel == 2) ? 16'h0000 : 16'($urandom);
      ap = ^a; bp = ^b; bad = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(1, 3);
        if (sel[0]) ap = ~ap;
        if (sel[1]) bp = ~bp;
        bad = 1'b1;
      end
      exp_q.push_back(bad ? 32'd0 : 32'($signed(a) * $signed(b)));
      do_req(a, ap, b, bp, ak, ea, rak, lat, res, rp, pe, ra, hr, xa);
      exp_r = exp_q.pop_front();
      if (ak !== 1'b1 || ea !== 1'b0 || rak !== 32'd0) begin
        errors++; $display("FAIL rnd%0d_accept: got ack=%b perr=%b res=%h want 1/0/0", n, ak, ea, rak);
      end
      checks++;
      if (lat !== (bad ? 1 : 17)) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, bad ? 1 : 17);
      end
      checks++;
      if (res !== exp_r || rp !== ^exp_r) begin
        errors++; $display("FAIL rnd%0d_result: a=%h b=%h got %h/%b want %h/%b", n, a, b, res, rp, exp_r, ^exp_r);
      end
      checks++;
      if (pe !== bad) begin errors++; $display("FAIL rnd%0d_perr: got %b want %b", n, pe, bad); end
      checks++;
      if (ra !== 1'b0 || xa !== 0) begin
        errors++; $display("FAIL rnd%0d_pulses: rdy_after=%b extra_acks=%0d want 0/0", n, ra, xa);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_parity_error();
    test_held_req();
    test_reset_mid_calc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
